// File: rtl/seq_multiplier_pkg.sv
// Shared types for the iterative shift-add multiplier: FSM state encoding
// and the width helper for the iteration counter.
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter must hold the value BITS itself, not just BITS-1.
   function automatic int count_width(input int bits);
      return $clog2(bits + 1);
   endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// BITS-wide ripple-carry adder used for the accumulate step of the
// shift-add multiplier.
module seq_multiplier_adder #(
   parameter int BITS = 4
) (
   input  logic [BITS-1:0] augend,
   input  logic [BITS-1:0] addend,
   output logic [BITS-1:0] sum,
   output logic            carry
);

   logic [BITS:0] chain;

   assign chain[0] = 1'b0;

   for (genvar i = 0; i < BITS; i++) begin : g_bit
      assign sum[i]       = augend[i] ^ addend[i] ^ chain[i];
      assign chain[i+1]   = (augend[i] & addend[i]) | (chain[i] & (augend[i] ^ addend[i]));
   end

   assign carry = chain[BITS];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one iteration per clock, with optional
// two's-complement operands handled by sign-magnitude conversion.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_signed,
   input  logic [BITS-1:0]   i_multiplicand,
   input  logic [BITS-1:0]   i_multiplier,
   output logic              o_ready,
   output logic              o_finished,
   output logic [2*BITS-1:0] o_product
);

   localparam int COUNT_W = count_width(BITS);

   state_t              state;
   state_t              next_state;
   logic [COUNT_W-1:0]  counter;
   logic [2*BITS-1:0]   acc;
   logic [2*BITS-1:0]   next_acc;
   logic [2*BITS-1:0]   product;
   logic [BITS-1:0]     mcand;
   logic [BITS-1:0]     mag_a;
   logic [BITS-1:0]     mag_b;
   logic [BITS-1:0]     addend;
   logic [BITS-1:0]     sum;
   logic                carry;
   logic                neg_flag;
   logic                load;
   logic                last_iter;

   // The most negative operand negates to 2^(BITS-1), which still fits
   // as an unsigned BITS-bit magnitude.
   assign mag_a = (i_signed && i_multiplicand[BITS-1]) ? -i_multiplicand : i_multiplicand;
   assign mag_b = (i_signed && i_multiplier[BITS-1])   ? -i_multiplier   : i_multiplier;

   assign addend = acc[0] ? mcand : '0;

   seq_multiplier_adder #(
      .BITS (BITS)
   ) u_adder (
      .augend (acc[2*BITS-1:BITS]),
      .addend (addend),
      .sum    (sum),
      .carry  (carry)
   );

   assign next_acc  = {carry, sum, acc[BITS-1:1]};
   assign last_iter = (counter == COUNT_W'(1));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      o_ready    = 1'b1;
      o_finished = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            o_ready = 1'b0;
            if (last_iter) begin
               next_state = DONE;
            end
         end
         DONE: begin
            o_finished = 1'b1;
            if (i_start) begin
               load       = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // The final iteration's edge publishes the product straight from next_acc,
   // so the result is visible in the same cycle that DONE is entered.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         counter  <= '0;
         acc      <= '0;
         mcand    <= '0;
         neg_flag <= 1'b0;
         product  <= '0;
      end else if (load) begin
         counter  <= COUNT_W'(BITS);
         acc      <= {{BITS{1'b0}}, mag_b};
         mcand    <= mag_a;
         neg_flag <= i_signed & (i_multiplicand[BITS-1] ^ i_multiplier[BITS-1]);
      end else if (state == RUN) begin
         acc     <= next_acc;
         counter <= counter - COUNT_W'(1);
         if (last_iter) begin
            product <= neg_flag ? -next_acc : next_acc;
         end
      end
   end

   assign o_product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases, exhaustive
// BITS=4 sweep in both modes, and random operations against an arithmetic model.
module tb_seq_multiplier;

   localparam int BITS = 4;

   logic              i_clock;
   logic              i_reset;
   logic              i_start;
   logic              i_signed;
   logic [BITS-1:0]   i_multiplicand;
   logic [BITS-1:0]   i_multiplier;
   logic              o_ready;
   logic              o_finished;
   logic [2*BITS-1:0] o_product;

   int check_count;
   int error_count;
   int starts_issued;
   int finished_seen;
   logic [2*BITS-1:0] last_product;

   seq_multiplier #(
      .BITS (BITS)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_signed       (i_signed),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_ready        (o_ready),
      .o_finished     (o_finished),
      .o_product      (o_product)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   always @(negedge i_clock) begin
      if (o_finished === 1'b1) begin
         finished_seen++;
      end
   end

   // Reference product computed with plain integer arithmetic.
   function automatic logic [2*BITS-1:0] ref_product(input logic [BITS-1:0] a,
                                                     input logic [BITS-1:0] b,
                                                     input logic sgn);
      longint x;
      longint y;
      x = sgn ? longint'($signed(a)) : longint'(a);
      y = sgn ? longint'($signed(b)) : longint'(b);
      return (2*BITS)'(x * y);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // One complete operation starting from a non-RUN state, with timing checks.
   task automatic applyStimulus(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                input logic sgn, input logic [2*BITS-1:0] expected);
      @(negedge i_clock);
      i_start        = 1'b1;
      i_signed       = sgn;
      i_multiplicand = a;
      i_multiplier   = b;
      checkOutput("ready_before_start", 64'(o_ready), 64'd1);
      @(posedge i_clock);
      #1;
      i_start        = 1'b0;
      i_signed       = 1'($urandom);
      i_multiplicand = BITS'($urandom);
      i_multiplier   = BITS'($urandom);
      starts_issued++;
      for (int k = 0; k < BITS; k++) begin
         @(negedge i_clock);
         checkOutput("busy_ready", 64'(o_ready), 64'd0);
         checkOutput("busy_finished", 64'(o_finished), 64'd0);
         checkOutput("busy_product_hold", 64'(o_product), 64'(last_product));
      end
      @(negedge i_clock);
      checkOutput("done_finished", 64'(o_finished), 64'd1);
      checkOutput("done_ready", 64'(o_ready), 64'd1);
      checkOutput("done_product", 64'(o_product), 64'(expected));
      last_product = expected;
   endtask

   initial begin
      check_count    = 0;
      error_count    = 0;
      starts_issued  = 0;
      finished_seen  = 0;
      last_product   = '0;
      i_reset        = 1'b1;
      i_start        = 1'b0;
      i_signed       = 1'b0;
      i_multiplicand = '0;
      i_multiplier   = '0;

      #2 i_reset = 1'b0;
      #1;
      checkOutput("reset_product", 64'(o_product), 64'd0);
      checkOutput("reset_ready", 64'(o_ready), 64'd1);
      checkOutput("reset_finished", 64'(o_finished), 64'd0);
      repeat (2) @(negedge i_clock);
      i_reset = 1'b1;

      applyStimulus(4'd11, 4'd13, 1'b0, 8'h8F);
      applyStimulus(4'hD,  4'd5,  1'b1, 8'hF1);
      applyStimulus(4'h8,  4'h8,  1'b1, 8'h40);
      applyStimulus(4'h8,  4'd7,  1'b1, 8'hC8);
      applyStimulus(4'd0,  4'd9,  1'b0, 8'h00);
      applyStimulus(4'd15, 4'd15, 1'b1, 8'h01);

      // Back-to-back with start held: results at E+4 and E+9, no idle gap.
      @(negedge i_clock);
      i_start = 1'b1; i_signed = 1'b0; i_multiplicand = 4'd11; i_multiplier = 4'd13;
      @(posedge i_clock);
      #1;
      i_multiplicand = 4'd15; i_multiplier = 4'd15;
      for (int k = 0; k < BITS; k++) begin
         @(negedge i_clock);
         checkOutput("b2b_first_busy", 64'(o_finished), 64'd0);
      end
      @(negedge i_clock);
      checkOutput("b2b_first_finished", 64'(o_finished), 64'd1);
      checkOutput("b2b_first_product", 64'(o_product), 64'd143);
      for (int k = 0; k < BITS; k++) begin
         @(negedge i_clock);
         checkOutput("b2b_second_ready", 64'(o_ready), 64'd0);
         checkOutput("b2b_second_busy", 64'(o_finished), 64'd0);
         checkOutput("b2b_product_hold", 64'(o_product), 64'd143);
      end
      @(negedge i_clock);
      checkOutput("b2b_second_finished", 64'(o_finished), 64'd1);
      checkOutput("b2b_second_product", 64'(o_product), 64'd225);
      i_start = 1'b0;
      starts_issued += 2;
      @(negedge i_clock);
      checkOutput("b2b_idle_ready", 64'(o_ready), 64'd1);
      checkOutput("b2b_idle_finished", 64'(o_finished), 64'd0);

      // Start and operand changes during RUN must be ignored.
      i_start = 1'b1; i_signed = 1'b0; i_multiplicand = 4'd7; i_multiplier = 4'd6;
      @(posedge i_clock);
      #1;
      i_multiplicand = 4'd2; i_multiplier = 4'd2;
      for (int k = 0; k < BITS; k++) begin
         @(negedge i_clock);
         checkOutput("ignore_busy", 64'(o_finished), 64'd0);
      end
      @(negedge i_clock);
      checkOutput("ignore_finished", 64'(o_finished), 64'd1);
      checkOutput("ignore_product", 64'(o_product), 64'd42);
      i_start = 1'b0;
      starts_issued++;
      @(negedge i_clock);
      checkOutput("ignore_single_pulse", 64'(o_finished), 64'd0);
      checkOutput("ignore_idle_ready", 64'(o_ready), 64'd1);

      // Asynchronous reset two cycles into an operation discards it.
      i_start = 1'b1; i_multiplicand = 4'd11; i_multiplier = 4'd13;
      @(posedge i_clock);
      #1 i_start = 1'b0;
      @(posedge i_clock);
      @(posedge i_clock);
      #2 i_reset = 1'b0;
      #1;
      checkOutput("midreset_product", 64'(o_product), 64'd0);
      checkOutput("midreset_ready", 64'(o_ready), 64'd1);
      checkOutput("midreset_finished", 64'(o_finished), 64'd0);
      last_product = '0;
      repeat (3) begin
         @(negedge i_clock);
         checkOutput("midreset_no_finish", 64'(o_finished), 64'd0);
      end
      i_reset = 1'b1;
      repeat (BITS + 1) begin
         @(negedge i_clock);
         checkOutput("midreset_no_late_finish", 64'(o_finished), 64'd0);
      end
      applyStimulus(4'd3, 4'd3, 1'b0, 8'd9);

      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 2**BITS; a++) begin
            for (int b = 0; b < 2**BITS; b++) begin
               applyStimulus(BITS'(a), BITS'(b), 1'(s), ref_product(BITS'(a), BITS'(b), 1'(s)));
            end
         end
      end

      for (int n = 0; n < 40; n++) begin
         logic [BITS-1:0] ra;
         logic [BITS-1:0] rb;
         logic            rs;
         ra = BITS'($urandom);
         rb = BITS'($urandom);
         rs = 1'($urandom);
         applyStimulus(ra, rb, rs, ref_product(ra, rb, rs));
      end

      @(negedge i_clock);
      checkOutput("finished_count", 64'(finished_seen), 64'(starts_issued));

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
